// File: rtl/sc_regfile_muxx_if.sv
// ---------------------------------------------------------------------------
// sc_regfile_muxx_if
// Bus bundle for the sc_regfile_muxx register file. It carries one write port
// (C) and two read ports (A, B). Each read port picks its register index from
// either an instruction-field (scratchpad) address or an MIR address.
//
// Modports:
//   master - the controller side. It drives the write/read requests and
//            observes the read data and status.
//   slave  - the register file side. It receives the requests and drives the
//            read data, Valid_Out and AddrError_Out.
//
// Signals:
//   SC_REGFILE_WriteEn_In / WriteAddr_InBus / WriteData_InBus  write port C
//   SC_REGFILE_ReadEn_In                                       read launch (A and B)
//   SC_REGFILE_{A,B}_Select_In                                 0 = scratchpad, 1 = MIR
//   SC_REGFILE_{A,B}_ScratchpadSelection_InBus                 instruction-field index
//   SC_REGFILE_{A,B}_MIRSelection_InBus                        MIR-field index
//   SC_REGFILE_{A,B}_data_OutBus                               registered read data
//   SC_REGFILE_Valid_Out                                       read data valid
//   SC_REGFILE_AddrError_Out                                   sticky bad-address flag
// ---------------------------------------------------------------------------
interface sc_regfile_muxx_if #(
  parameter int DATAWIDTH_BUS                  = 32,
  parameter int DATAWIDTH_SCRATCHPAD_SELECTION = 5,
  parameter int DATAWIDTH_MIR_SELECTION        = 6
);
  logic                                      SC_REGFILE_WriteEn_In;
  logic [DATAWIDTH_MIR_SELECTION-1:0]        SC_REGFILE_WriteAddr_InBus;
  logic [DATAWIDTH_BUS-1:0]                  SC_REGFILE_WriteData_InBus;
  logic                                      SC_REGFILE_ReadEn_In;
  logic                                      SC_REGFILE_A_Select_In;
  logic                                      SC_REGFILE_B_Select_In;
  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] SC_REGFILE_A_ScratchpadSelection_InBus;
  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] SC_REGFILE_B_ScratchpadSelection_InBus;
  logic [DATAWIDTH_MIR_SELECTION-1:0]        SC_REGFILE_A_MIRSelection_InBus;
  logic [DATAWIDTH_MIR_SELECTION-1:0]        SC_REGFILE_B_MIRSelection_InBus;
  logic [DATAWIDTH_BUS-1:0]                  SC_REGFILE_A_data_OutBus;
  logic [DATAWIDTH_BUS-1:0]                  SC_REGFILE_B_data_OutBus;
  logic                                      SC_REGFILE_Valid_Out;
  logic                                      SC_REGFILE_AddrError_Out;

  modport master (
    output SC_REGFILE_WriteEn_In, SC_REGFILE_WriteAddr_InBus, SC_REGFILE_WriteData_InBus,
    output SC_REGFILE_ReadEn_In,
    output SC_REGFILE_A_Select_In, SC_REGFILE_B_Select_In,
    output SC_REGFILE_A_ScratchpadSelection_InBus, SC_REGFILE_B_ScratchpadSelection_InBus,
    output SC_REGFILE_A_MIRSelection_InBus, SC_REGFILE_B_MIRSelection_InBus,
    input  SC_REGFILE_A_data_OutBus, SC_REGFILE_B_data_OutBus,
    input  SC_REGFILE_Valid_Out, SC_REGFILE_AddrError_Out
  );

  modport slave (
    input  SC_REGFILE_WriteEn_In, SC_REGFILE_WriteAddr_InBus, SC_REGFILE_WriteData_InBus,
    input  SC_REGFILE_ReadEn_In,
    input  SC_REGFILE_A_Select_In, SC_REGFILE_B_Select_In,
    input  SC_REGFILE_A_ScratchpadSelection_InBus, SC_REGFILE_B_ScratchpadSelection_InBus,
    input  SC_REGFILE_A_MIRSelection_InBus, SC_REGFILE_B_MIRSelection_InBus,
    output SC_REGFILE_A_data_OutBus, SC_REGFILE_B_data_OutBus,
    output SC_REGFILE_Valid_Out, SC_REGFILE_AddrError_Out
  );
endinterface

// File: rtl/sc_regfile_muxx.sv
// ---------------------------------------------------------------------------
// sc_regfile_muxx
// A register file with NUM_REGS entries, one write port and two read ports.
// Register 0 is hard-wired to zero. Reads have a latency of one cycle, and
// the outputs hold their value while no read is requested. If a read and a
// write hit the same register on the same edge, the read returns the new
// write data (write-first). An out-of-range read index returns zero. Any
// out-of-range read or write index sets a sticky error flag, and only reset
// clears it.
//
// Ports:
//   SC_REGFILE_CLOCK_50      clock; all state changes on the rising edge
//   SC_REGFILE_RESET_InHigh  asynchronous active-high reset; clears all state
//   bus                      sc_regfile_muxx_if.slave (write port, read ports, status)
// ---------------------------------------------------------------------------
module sc_regfile_muxx #(
  parameter int DATAWIDTH_BUS                  = 32,
  parameter int NUM_REGS                       = 16,
  parameter int DATAWIDTH_SCRATCHPAD_SELECTION = 5,
  parameter int DATAWIDTH_MIR_SELECTION        = 6
) (
  input  logic                SC_REGFILE_CLOCK_50,
  input  logic                SC_REGFILE_RESET_InHigh,
  sc_regfile_muxx_if.slave    bus
);

  // Number of address bits needed to index the physical array. The range
  // check is done on the full-width index, so the dropped upper bits are
  // never needed to pick a register.
  localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  typedef logic [DATAWIDTH_MIR_SELECTION-1:0] idx_t;
  typedef logic [DATAWIDTH_BUS-1:0]           data_t;

  data_t r_regs [NUM_REGS];
  data_t r_a_data;
  data_t r_b_data;
  logic  r_valid;
  logic  r_addr_error;

  idx_t  w_a_idx;
  idx_t  w_b_idx;
  logic  w_a_oob;
  logic  w_b_oob;
  logic  w_wr_oob;
  logic  w_wr_legal;
  data_t w_a_stored;
  data_t w_b_stored;
  data_t w_a_next;
  data_t w_b_next;

  // The compare is done at 32 bits, so NUM_REGS == 2**DATAWIDTH_MIR_SELECTION
  // does not wrap to zero.
  function automatic logic in_range(input idx_t idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  // Read-port value. Out-of-range indices and index 0 read as zero. A legal
  // write to the same index on this edge is forwarded.
  function automatic data_t read_port(input idx_t  idx,
                                      input data_t stored,
                                      input logic  wr_legal,
                                      input idx_t  wr_idx,
                                      input data_t wr_data);
    data_t v;
    v = '0;
    if (in_range(idx) && idx != '0) begin
      v = (wr_legal && wr_idx == idx) ? wr_data : stored;
    end
    return v;
  endfunction

  // A scratchpad index is zero-extended to the width of an MIR index.
  assign w_a_idx = bus.SC_REGFILE_A_Select_In ? bus.SC_REGFILE_A_MIRSelection_InBus
                 : idx_t'(bus.SC_REGFILE_A_ScratchpadSelection_InBus);
  assign w_b_idx = bus.SC_REGFILE_B_Select_In ? bus.SC_REGFILE_B_MIRSelection_InBus
                 : idx_t'(bus.SC_REGFILE_B_ScratchpadSelection_InBus);

  assign w_a_oob  = !in_range(w_a_idx);
  assign w_b_oob  = !in_range(w_b_idx);
  assign w_wr_oob = !in_range(bus.SC_REGFILE_WriteAddr_InBus);

  // A write to index 0 is a legal no-op. It is dropped here and is not
  // flagged as an error.
  assign w_wr_legal = bus.SC_REGFILE_WriteEn_In && !w_wr_oob
                    && (bus.SC_REGFILE_WriteAddr_InBus != '0);

  assign w_a_stored = r_regs[w_a_idx[IDX_W-1:0]];
  assign w_b_stored = r_regs[w_b_idx[IDX_W-1:0]];

  // NOTE: every output of a combinational block gets a value on every path.
  // Here the function's first statement is the default, so no latch can be
  // inferred.
  always_comb begin
    w_a_next = read_port(w_a_idx, w_a_stored, w_wr_legal,
                         bus.SC_REGFILE_WriteAddr_InBus, bus.SC_REGFILE_WriteData_InBus);
    w_b_next = read_port(w_b_idx, w_b_stored, w_wr_legal,
                         bus.SC_REGFILE_WriteAddr_InBus, bus.SC_REGFILE_WriteData_InBus);
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample pre-edge values, and the order of the statements does not
  // matter.
  always_ff @(posedge SC_REGFILE_CLOCK_50 or posedge SC_REGFILE_RESET_InHigh) begin
    if (SC_REGFILE_RESET_InHigh) begin
      // NOTE: the whole array is reset on purpose. After reset, every
      // register must read as zero, so the array is built from flops, not
      // from an inferred RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_a_data     <= '0;
      r_b_data     <= '0;
      r_valid      <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      if (w_wr_legal) begin
        r_regs[bus.SC_REGFILE_WriteAddr_InBus[IDX_W-1:0]] <= bus.SC_REGFILE_WriteData_InBus;
      end

      r_valid <= bus.SC_REGFILE_ReadEn_In;
      if (bus.SC_REGFILE_ReadEn_In) begin
        r_a_data <= w_a_next;
        r_b_data <= w_b_next;
      end

      // Sticky: this path can set the flag but never clears it.
      if ((bus.SC_REGFILE_ReadEn_In && (w_a_oob || w_b_oob)) ||
          (bus.SC_REGFILE_WriteEn_In && w_wr_oob)) begin
        r_addr_error <= 1'b1;
      end
    end
  end

  assign bus.SC_REGFILE_A_data_OutBus = r_a_data;
  assign bus.SC_REGFILE_B_data_OutBus = r_b_data;
  assign bus.SC_REGFILE_Valid_Out     = r_valid;
  assign bus.SC_REGFILE_AddrError_Out = r_addr_error;

endmodule

// File: tb/tb_sc_regfile_muxx.sv
// ---------------------------------------------------------------------------
// tb_sc_regfile_muxx
// Directed testbench for sc_regfile_muxx with the default parameters
// (32-bit data, 16 registers). Inputs change 1 ns after a rising edge.
// Outputs are sampled at the same point, so the result of the previous edge
// is visible.
// ---------------------------------------------------------------------------
module tb_sc_regfile_muxx;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_failures;

  sc_regfile_muxx_if #(
    .DATAWIDTH_BUS(32),
    .DATAWIDTH_SCRATCHPAD_SELECTION(5),
    .DATAWIDTH_MIR_SELECTION(6)
  ) bus ();

  sc_regfile_muxx #(
    .DATAWIDTH_BUS(32),
    .NUM_REGS(16),
    .DATAWIDTH_SCRATCHPAD_SELECTION(5),
    .DATAWIDTH_MIR_SELECTION(6)
  ) dut (
    .SC_REGFILE_CLOCK_50(clk),
    .SC_REGFILE_RESET_InHigh(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic we, input logic [5:0] wa, input logic [31:0] wd);
    bus.SC_REGFILE_WriteEn_In      = we;
    bus.SC_REGFILE_WriteAddr_InBus = wa;
    bus.SC_REGFILE_WriteData_InBus = wd;
  endtask

  task automatic set_read(input logic re,
                          input logic as, input logic [4:0] asc, input logic [5:0] am,
                          input logic bs, input logic [4:0] bsc, input logic [5:0] bm);
    bus.SC_REGFILE_ReadEn_In                   = re;
    bus.SC_REGFILE_A_Select_In                 = as;
    bus.SC_REGFILE_A_ScratchpadSelection_InBus = asc;
    bus.SC_REGFILE_A_MIRSelection_InBus        = am;
    bus.SC_REGFILE_B_Select_In                 = bs;
    bus.SC_REGFILE_B_ScratchpadSelection_InBus = bsc;
    bus.SC_REGFILE_B_MIRSelection_InBus        = bm;
  endtask

  task automatic idle();
    set_write(1'b0, 6'd0, 32'h0);
    set_read(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_failures = 0;
    rst = 1'b1;
    idle();

    // Reset state
    #25;
    check("rst_a",     bus.SC_REGFILE_A_data_OutBus, 32'h0);
    check("rst_b",     bus.SC_REGFILE_B_data_OutBus, 32'h0);
    check("rst_valid", 32'(bus.SC_REGFILE_Valid_Out), 32'h0);
    check("rst_err",   32'(bus.SC_REGFILE_AddrError_Out), 32'h0);
    rst = 1'b0;

    // Write r5, then read it through A (MIR select)
    set_write(1'b1, 6'd5, 32'hDEADBEEF);
    cyc();
    check("wr5_valid_low", 32'(bus.SC_REGFILE_Valid_Out), 32'h0);
    set_write(1'b0, 6'd0, 32'h0);
    set_read(1'b1, 1'b1, 5'd0, 6'd5, 1'b0, 5'd0, 6'd0);
    cyc();
    check("rd5_a",     bus.SC_REGFILE_A_data_OutBus, 32'hDEADBEEF);
    check("rd5_valid", 32'(bus.SC_REGFILE_Valid_Out), 32'h1);

    // Write to r0 is discarded, no error; A reads it via scratchpad index 0
    set_write(1'b1, 6'd0, 32'h12345678);
    set_read(1'b1, 1'b0, 5'd0, 6'd5, 1'b1, 5'd0, 6'd5);
    cyc();
    check("r0_a",   bus.SC_REGFILE_A_data_OutBus, 32'h0);
    check("r0_err", 32'(bus.SC_REGFILE_AddrError_Out), 32'h0);
    check("r0_b_r5", bus.SC_REGFILE_B_data_OutBus, 32'hDEADBEEF);

    // Same-edge write/read bypass of r7 on both ports
    set_write(1'b1, 6'd7, 32'hCAFEF00D);
    set_read(1'b1, 1'b1, 5'd0, 6'd7, 1'b0, 5'd7, 6'd0);
    cyc();
    check("byp7_a", bus.SC_REGFILE_A_data_OutBus, 32'hCAFEF00D);
    check("byp7_b", bus.SC_REGFILE_B_data_OutBus, 32'hCAFEF00D);

    // Both ports on the same register; also confirms r7 was stored
    set_write(1'b0, 6'd0, 32'h0);
    set_read(1'b1, 1'b1, 5'd0, 6'd5, 1'b1, 5'd0, 6'd5);
    cyc();
    check("same_a", bus.SC_REGFILE_A_data_OutBus, 32'hDEADBEEF);
    check("same_b", bus.SC_REGFILE_B_data_OutBus, 32'hDEADBEEF);
    set_read(1'b1, 1'b0, 5'd7, 6'd0, 1'b1, 5'd0, 6'd7);
    cyc();
    check("st7_a", bus.SC_REGFILE_A_data_OutBus, 32'hCAFEF00D);
    check("st7_b", bus.SC_REGFILE_B_data_OutBus, 32'hCAFEF00D);

    // ReadEn 1,1,0 on r3/r4
    set_read(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0);
    set_write(1'b1, 6'd3, 32'h11);
    cyc();
    set_write(1'b1, 6'd4, 32'h22);
    cyc();
    set_write(1'b0, 6'd0, 32'h0);
    set_read(1'b1, 1'b1, 5'd0, 6'd3, 1'b0, 5'd0, 6'd0);
    cyc();
    check("seq1_a", bus.SC_REGFILE_A_data_OutBus, 32'h11);
    check("seq1_v", 32'(bus.SC_REGFILE_Valid_Out), 32'h1);
    set_read(1'b1, 1'b1, 5'd0, 6'd4, 1'b0, 5'd0, 6'd0);
    cyc();
    check("seq2_a", bus.SC_REGFILE_A_data_OutBus, 32'h22);
    check("seq2_v", 32'(bus.SC_REGFILE_Valid_Out), 32'h1);
    set_read(1'b0, 1'b1, 5'd0, 6'd3, 1'b0, 5'd0, 6'd0);
    cyc();
    check("seq3_hold", bus.SC_REGFILE_A_data_OutBus, 32'h22);
    check("seq3_v",    32'(bus.SC_REGFILE_Valid_Out), 32'h0);

    // Out-of-range write (18 aliases r2 in the low bits) must not touch r2
    set_read(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0);
    set_write(1'b1, 6'd2, 32'h0000AAAA);
    cyc();
    check("pre_oobw_err", 32'(bus.SC_REGFILE_AddrError_Out), 32'h0);
    set_write(1'b1, 6'd18, 32'h00005555);
    cyc();
    check("oobw_err", 32'(bus.SC_REGFILE_AddrError_Out), 32'h1);
    set_write(1'b0, 6'd0, 32'h0);
    set_read(1'b1, 1'b1, 5'd0, 6'd2, 1'b0, 5'd0, 6'd0);
    cyc();
    check("oobw_r2", bus.SC_REGFILE_A_data_OutBus, 32'h0000AAAA);

    // Asynchronous reset pulse clears the sticky error and the array
    idle();
    #4 rst = 1'b1;
    #1;
    check("rst2_err", 32'(bus.SC_REGFILE_AddrError_Out), 32'h0);
    check("rst2_a",   bus.SC_REGFILE_A_data_OutBus, 32'h0);
    #2 rst = 1'b0;

    // Out-of-range read on B; B is first loaded nonzero
    set_write(1'b1, 6'd6, 32'h66);
    set_read(1'b1, 1'b1, 5'd0, 6'd5, 1'b1, 5'd0, 6'd6);
    cyc();
    check("pre_oobr_b", bus.SC_REGFILE_B_data_OutBus, 32'h66);
    check("r5_cleared", bus.SC_REGFILE_A_data_OutBus, 32'h0);
    set_write(1'b0, 6'd0, 32'h0);
    set_read(1'b1, 1'b1, 5'd0, 6'd6, 1'b1, 5'd0, 6'd20);
    cyc();
    check("oobr_b",   bus.SC_REGFILE_B_data_OutBus, 32'h0);
    check("oobr_a",   bus.SC_REGFILE_A_data_OutBus, 32'h66);
    check("oobr_err", 32'(bus.SC_REGFILE_AddrError_Out), 32'h1);
    idle();
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("sticky_%0d", i), 32'(bus.SC_REGFILE_AddrError_Out), 32'h1);
    end

    // Reset mid-cycle after a write/bypass read of r9
    set_write(1'b1, 6'd9, 32'hFFFF0000);
    set_read(1'b1, 1'b1, 5'd0, 6'd9, 1'b0, 5'd0, 6'd0);
    cyc();
    check("r9_byp", bus.SC_REGFILE_A_data_OutBus, 32'hFFFF0000);
    idle();
    #4 rst = 1'b1;
    #1;
    check("r9_rst_a",   bus.SC_REGFILE_A_data_OutBus, 32'h0);
    check("r9_rst_v",   32'(bus.SC_REGFILE_Valid_Out), 32'h0);
    check("r9_rst_err", 32'(bus.SC_REGFILE_AddrError_Out), 32'h0);
    #2 rst = 1'b0;
    set_read(1'b1, 1'b1, 5'd0, 6'd9, 1'b0, 5'd9, 6'd0);
    cyc();
    check("r9_post_a", bus.SC_REGFILE_A_data_OutBus, 32'h0);
    check("r9_post_b", bus.SC_REGFILE_B_data_OutBus, 32'h0);
    check("r9_post_v", 32'(bus.SC_REGFILE_Valid_Out), 32'h1);

    idle();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
